// File: rtl/frame_arb_pkg.sv
// Shared types and the round-robin priority helper for frame-level stream arbiters.
package frame_arb_pkg;

   localparam int unsigned MAX_SRC     = 8;
   localparam int unsigned MAX_GW      = 3;
   localparam int unsigned NUM_SRC_DEF = 4;
   localparam int unsigned GRANT_W     = $clog2(NUM_SRC_DEF);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      GAP  = 2'd2
   } arb_state_e;

   // First valid index after 'last', wrapping modulo n; returns 'last' when nothing is valid.
   function automatic logic [MAX_GW-1:0] next_grant(
      input logic [MAX_SRC-1:0] valid,
      input logic [MAX_GW-1:0]  last,
      input int unsigned        n
   );
      logic [MAX_GW-1:0] pick;
      logic [MAX_GW-1:0] idx;
      pick = last;
      for (int off = int'(MAX_SRC); off > 0; off--) begin
         if (off <= int'(n)) begin
            idx = MAX_GW'((int'(last) + off) % int'(n));
            if (valid[idx]) pick = idx;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/frame_rr_arbiter_rr_pick.sv
// Combinational rotating-priority encoder: picks the next requester after last_grant.
module rr_pick
   import frame_arb_pkg::*;
#(
   parameter int unsigned N  = 4,
   parameter int unsigned GW = 2
) (
   input  logic [N-1:0]  valid,
   input  logic [GW-1:0] last_grant,
   output logic [GW-1:0] grant_c,
   output logic          any_valid_c
);

   logic [MAX_GW-1:0] pick;

   always_comb begin
      pick        = next_grant(MAX_SRC'(valid), MAX_GW'(last_grant), N);
      grant_c     = GW'(pick);
      any_valid_c = |valid;
   end

endmodule

// File: rtl/frame_rr_arbiter.sv
// Whole-frame round-robin arbiter feeding a single AXI-Stream sink, with an
// enforced idle gap after every frame.
module frame_rr_arbiter
   import frame_arb_pkg::*;
#(
   parameter int unsigned NUM_SRC    = 4,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned BYTE_NUM   = 4,
   parameter int unsigned LEN_WIDTH  = 32,
   parameter int unsigned GAP_CYCLES = 10,
   localparam int unsigned GW        = $clog2(NUM_SRC)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [NUM_SRC*BYTE_NUM-1:0]   s_axis_tkeep,
   input  logic [NUM_SRC-1:0]            s_axis_tvalid,
   input  logic [NUM_SRC-1:0]            s_axis_tlast,
   output logic [NUM_SRC-1:0]            s_axis_tready,
   input  logic [NUM_SRC*LEN_WIDTH-1:0]  s_length,
   output logic [DATA_WIDTH-1:0]         o_axis_tdata,
   output logic [BYTE_NUM-1:0]           o_axis_tkeep,
   output logic                          o_axis_tvalid,
   output logic                          o_axis_tlast,
   input  logic                          o_axis_tready,
   output logic [LEN_WIDTH-1:0]          o_length,
   output logic [GW-1:0]                 o_grant_idx,
   output logic                          o_frame_done
);

   localparam int unsigned CNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   arb_state_e           state_q, state_d;
   logic [GW-1:0]        grant_q, grant_d;
   logic [GW-1:0]        last_grant_q, last_grant_d;
   logic [LEN_WIDTH-1:0] length_q, length_d;
   logic [CNT_W-1:0]     gap_cnt_q, gap_cnt_d;
   logic [GW-1:0]        pick_c;
   logic                 any_valid_c;
   logic                 frame_done_c;

   rr_pick #(
      .N  (NUM_SRC),
      .GW (GW)
   ) u_rr_pick (
      .valid       (s_axis_tvalid),
      .last_grant  (last_grant_q),
      .grant_c     (pick_c),
      .any_valid_c (any_valid_c)
   );

   // Zero-latency pass-through of the granted source while a frame is open.
   always_comb begin
      o_axis_tdata  = '0;
      o_axis_tkeep  = '0;
      o_axis_tvalid = 1'b0;
      o_axis_tlast  = 1'b0;
      s_axis_tready = '0;
      if (state_q == XFER) begin
         o_axis_tdata           = s_axis_tdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
         o_axis_tkeep           = s_axis_tkeep[int'(grant_q)*BYTE_NUM +: BYTE_NUM];
         o_axis_tvalid          = s_axis_tvalid[grant_q];
         o_axis_tlast           = s_axis_tlast[grant_q];
         s_axis_tready[grant_q] = o_axis_tready;
      end
      frame_done_c = o_axis_tvalid & o_axis_tready & o_axis_tlast;
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      length_d     = length_q;
      gap_cnt_d    = gap_cnt_q;
      case (state_q)
         IDLE: begin
            if (any_valid_c) begin
               grant_d  = pick_c;
               length_d = s_length[int'(pick_c)*LEN_WIDTH +: LEN_WIDTH];
               state_d  = XFER;
            end
         end
         XFER: begin
            // Grant is held until tlast is accepted; no preemption.
            if (frame_done_c) begin
               last_grant_d = grant_q;
               gap_cnt_d    = '0;
               state_d      = (GAP_CYCLES > 0) ? GAP : IDLE;
            end
         end
         GAP: begin
            if (gap_cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
               gap_cnt_d = '0;
               state_d   = IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         last_grant_q <= GW'(NUM_SRC - 1);
         length_q     <= '0;
         gap_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         length_q     <= length_d;
         gap_cnt_q    <= gap_cnt_d;
      end
   end

   assign o_grant_idx  = grant_q;
   assign o_length     = length_q;
   assign o_frame_done = frame_done_c;

endmodule

// File: tb/tb_frame_rr_arbiter.sv
// Directed bench for frame_rr_arbiter: long frame, reset mid-frame, rotation, backpressure and stalls.
module tb_frame_rr_arbiter;

   localparam int unsigned NS = 4;
   localparam int unsigned DW = 32;
   localparam int unsigned BN = 4;
   localparam int unsigned LW = 32;
   localparam int unsigned G  = 10;
   localparam int unsigned GW = 2;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [NS*DW-1:0] s_tdata = '0;
   logic [NS*BN-1:0] s_tkeep = '0;
   logic [NS-1:0]    s_tvalid = '0;
   logic [NS-1:0]    s_tlast = '0;
   logic [NS-1:0]    s_tready;
   logic [NS*LW-1:0] s_len = '0;
   logic [DW-1:0]    o_tdata;
   logic [BN-1:0]    o_tkeep;
   logic             o_tvalid;
   logic             o_tlast;
   logic             o_tready = 1'b0;
   logic [LW-1:0]    o_len;
   logic [GW-1:0]    o_grant;
   logic             o_done;

   int checks = 0;
   int failures = 0;

   frame_rr_arbiter #(
      .NUM_SRC    (NS),
      .DATA_WIDTH (DW),
      .BYTE_NUM   (BN),
      .LEN_WIDTH  (LW),
      .GAP_CYCLES (G)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .s_axis_tdata  (s_tdata),
      .s_axis_tkeep  (s_tkeep),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tlast  (s_tlast),
      .s_axis_tready (s_tready),
      .s_length      (s_len),
      .o_axis_tdata  (o_tdata),
      .o_axis_tkeep  (o_tkeep),
      .o_axis_tvalid (o_tvalid),
      .o_axis_tlast  (o_tlast),
      .o_axis_tready (o_tready),
      .o_length      (o_len),
      .o_grant_idx   (o_grant),
      .o_frame_done  (o_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after posedge; outputs are sampled 1 unit later.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_src(input int k, input logic v, input logic [DW-1:0] d,
                          input logic [BN-1:0] kp, input logic l, input logic [LW-1:0] len);
      s_tvalid[k]          = v;
      s_tdata[k*DW +: DW]  = d;
      s_tkeep[k*BN +: BN]  = kp;
      s_tlast[k]           = l;
      s_len[k*LW +: LW]    = len;
   endtask

   task automatic clear_srcs();
      s_tvalid = '0;
      s_tdata  = '0;
      s_tkeep  = '0;
      s_tlast  = '0;
      s_len    = '0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_tvalid"}, 64'(o_tvalid), 64'd0);
      chk({tag, "_tlast"},  64'(o_tlast),  64'd0);
      chk({tag, "_tdata"},  64'(o_tdata),  64'd0);
      chk({tag, "_tkeep"},  64'(o_tkeep),  64'd0);
      chk({tag, "_sready"}, 64'(s_tready), 64'd0);
      chk({tag, "_length"}, 64'(o_len),    64'd0);
      chk({tag, "_grant"},  64'(o_grant),  64'd0);
      chk({tag, "_done"},   64'(o_done),   64'd0);
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      o_tready = 1'b0;
      clear_srcs();
      cyc();
      cyc();
      #1;
      chk_zero("rst");
      rst_n = 1'b1;
   endtask

   initial begin
      int b2;
      int bc [NS];
      int n, p, f;
      logic [12:0] rdy_s;
      logic [12:0] v2_s;

      // ---- single source 0, 250-beat frame ----
      do_reset();
      o_tready = 1'b1;
      cyc();
      set_src(0, 1'b1, 32'h12345678, 4'hF, 1'b0, 32'd1000);
      #1;
      chk("t1_idle_tvalid", 64'(o_tvalid), 64'd0);
      chk("t1_idle_ready", 64'(s_tready), 64'd0);
      for (int i = 0; i < 250; i++) begin
         cyc();
         set_src(0, 1'b1, 32'h12345678 + 32'(i), 4'hF, (i == 249), 32'd1000);
         #1;
         chk("t1_tdata", 64'(o_tdata), 64'(32'h12345678 + 32'(i)));
         chk("t1_tvalid", 64'(o_tvalid), 64'd1);
         chk("t1_tlast", 64'(o_tlast), 64'(i == 249));
         chk("t1_sready", 64'(s_tready), 64'b0001);
         chk("t1_length", 64'(o_len), 64'd1000);
         chk("t1_done", 64'(o_done), 64'(i == 249));
         if (i == 249) chk("t1_tkeep_last", 64'(o_tkeep), 64'hF);
      end
      chk("t1_grant", 64'(o_grant), 64'd0);

      // ---- gap timing, then a new source-0 frame reset at beat 100 ----
      cyc();
      set_src(0, 1'b1, 32'hC0000000, 4'hF, 1'b0, 32'd1000);
      #1;
      chk("t6_gap1_tvalid", 64'(o_tvalid), 64'd0);
      chk("t6_gap1_done", 64'(o_done), 64'd0);
      for (int j = 2; j <= 11; j++) begin
         cyc();
         #1;
         chk("t6_gap_tvalid", 64'(o_tvalid), 64'd0);
         chk("t6_gap_sready", 64'(s_tready), 64'd0);
      end
      for (int i = 0; i <= 100; i++) begin
         cyc();
         set_src(0, 1'b1, 32'hC0000000 + 32'(i), 4'hF, 1'b0, 32'd1000);
         if (i == 100) begin
            set_src(1, 1'b1, 32'hD1D1D1D1, 4'h1, 1'b0, 32'd77);
            rst_n = 1'b0;
         end
         #1;
         chk("t6_tdata", 64'(o_tdata), 64'(32'hC0000000 + 32'(i)));
         chk("t6_tvalid", 64'(o_tvalid), 64'd1);
      end
      cyc();
      rst_n = 1'b1;
      #1;
      chk_zero("t6_after_rst");
      cyc();
      #1;
      chk("t6_regrant", 64'(o_grant), 64'd0);
      chk("t6_regrant_tdata", 64'(o_tdata), 64'(32'hC0000064));
      chk("t6_regrant_sready", 64'(s_tready), 64'b0001);
      chk("t6_regrant_length", 64'(o_len), 64'd1000);

      // ---- all four sources, 8-beat frames, rotation 0,1,2,3,0 ----
      do_reset();
      o_tready = 1'b1;
      for (int k = 0; k < NS; k++) bc[k] = 0;
      for (int c = 0; c <= 84; c++) begin
         cyc();
         for (int k = 0; k < NS; k++)
            set_src(k, 1'b1, {8'(k), 24'(bc[k])}, 4'hF, (bc[k] == 7), 32'd32 + 32'(k));
         #1;
         if (c == 0) begin
            chk("t2_idle_tvalid", 64'(o_tvalid), 64'd0);
         end else begin
            n = c - 1;
            p = n % 19;
            f = (n / 19) % 4;
            if (p < 8) begin
               chk("t2_tvalid", 64'(o_tvalid), 64'd1);
               chk("t2_grant", 64'(o_grant), 64'(f));
               chk("t2_tdata", 64'(o_tdata), 64'({8'(f), 24'(p)}));
               chk("t2_tlast", 64'(o_tlast), 64'(p == 7));
               chk("t2_sready", 64'(s_tready), 64'(4'b0001 << f));
               chk("t2_length", 64'(o_len), 64'(32 + f));
            end else begin
               chk("t2_gap_tvalid", 64'(o_tvalid), 64'd0);
               chk("t2_gap_sready", 64'(s_tready), 64'd0);
            end
         end
         for (int k = 0; k < NS; k++)
            if (s_tready[k]) bc[k] = (bc[k] + 1) % 8;
      end

      // ---- source 2 frame with backpressure and a 5-cycle stall, source 1 waiting ----
      do_reset();
      rdy_s = 13'b1111111111001;
      v2_s  = 13'b1111000001111;
      b2 = 0;
      cyc();
      set_src(2, 1'b1, 32'hA0, 4'hF, 1'b0, 32'h55);
      #1;
      chk("t3_idle_tvalid", 64'(o_tvalid), 64'd0);
      for (int s = 0; s <= 12; s++) begin
         cyc();
         o_tready = rdy_s[s];
         set_src(2, v2_s[s], 32'hA0 + 32'(b2), 4'hF, (b2 == 5), 32'h55);
         set_src(1, (s >= 1), 32'hB0, 4'h3, 1'b1, 32'd0);
         #1;
         chk("t3_tvalid", 64'(o_tvalid), 64'(v2_s[s]));
         chk("t3_sready", 64'(s_tready), 64'({1'b0, rdy_s[s], 2'b00}));
         chk("t3_grant", 64'(o_grant), 64'd2);
         chk("t3_length", 64'(o_len), 64'h55);
         chk("t3_done", 64'(o_done), 64'(v2_s[s] && rdy_s[s] && b2 == 5));
         if (v2_s[s]) chk("t3_tdata", 64'(o_tdata), 64'(32'hA0 + 32'(b2)));
         if (v2_s[s] && rdy_s[s]) b2++;
      end
      chk("t3_beats", 64'(b2), 64'd6);
      for (int j = 1; j <= 11; j++) begin
         cyc();
         o_tready = 1'b1;
         set_src(2, 1'b0, 32'h0, 4'h0, 1'b0, 32'h55);
         #1;
         chk("t3_gap_tvalid", 64'(o_tvalid), 64'd0);
         chk("t3_gap_sready", 64'(s_tready), 64'd0);
      end
      cyc();
      #1;
      chk("t3_next_grant", 64'(o_grant), 64'd1);
      chk("t3_next_tvalid", 64'(o_tvalid), 64'd1);
      chk("t3_next_tdata", 64'(o_tdata), 64'hB0);
      chk("t3_next_tkeep", 64'(o_tkeep), 64'h3);
      chk("t3_next_tlast", 64'(o_tlast), 64'd1);
      chk("t3_next_length", 64'(o_len), 64'd0);
      chk("t3_next_sready", 64'(s_tready), 64'b0010);
      chk("t3_next_done", 64'(o_done), 64'd1);
      cyc();
      clear_srcs();
      #1;
      chk("t3_post_tvalid", 64'(o_tvalid), 64'd0);
      chk("t3_post_done", 64'(o_done), 64'd0);
      chk("t3_post_grant", 64'(o_grant), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
